// File: rtl/garoa_div.sv
// Sequential GF(2^8) divider: d = x / y = x * y^254, one shared field multiplier
// time-multiplexed over 14 steps, start/done handshake.
module garoa_div #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] d,
  output logic       div_by_zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nx;
  logic [3:0] step, step_nx;
  logic [7:0] xr, xr_nx;
  logic [7:0] yr, yr_nx;
  logic [7:0] r, r_nx;
  logic       busy_nx, done_nx, dz_nx;
  logic [7:0] d_nx;
  logic [7:0] mul_b, prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? POLY : 8'h00);
    end
    return p;
  endfunction

  // Square-and-multiply chain for y^254: even steps square, odd steps multiply
  // by yr; step 13 applies the dividend.
  always_comb begin
    mul_b = (step == 4'd13) ? xr : (step[0] ? yr : r);
    prod  = gf_mul(r, mul_b);
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    xr_nx    = xr;
    yr_nx    = yr;
    r_nx     = r;
    busy_nx  = busy;
    done_nx  = 1'b0;
    d_nx     = d;
    dz_nx    = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          xr_nx    = x;
          yr_nx    = y;
          r_nx     = y;
          step_nx  = '0;
          busy_nx  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (step == 4'd13) begin
          d_nx     = prod;
          dz_nx    = (yr == '0);
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          step_nx  = '0;
          state_nx = IDLE;
        end else begin
          r_nx    = prod;
          step_nx = step + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      xr          <= '0;
      yr          <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      d           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      step        <= step_nx;
      xr          <= xr_nx;
      yr          <= yr_nx;
      r           <= r_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      d           <= d_nx;
      div_by_zero <= dz_nx;
    end
  end

endmodule

// File: tb/tb_garoa_div.sv
// Self-checking bench for garoa_div: directed vectors, handshake/reset cases and
// random operands checked against a polynomial-arithmetic reference model.
module tb_garoa_div;

  localparam logic [7:0] POLY = 8'h1B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] d;

  int total = 0;
  int bad = 0;

  garoa_div #(.POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .d(d), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Full carry-less product, then long division by x^8 + POLY.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] m;
    p = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j]) p[i+j] = ~p[i+j];
    for (int k = 14; k >= 8; k--) begin
      m = {6'b0, 1'b1, POLY} << (k - 8);
      if (p[k]) p = p ^ m;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] v);
    logic [7:0] z;
    for (int c = 1; c < 256; c++) begin
      z = c[7:0];
      if (ref_mul(v, z) == 8'h01) return z;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    return ref_mul(a, ref_inv(b));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Present operands and take the accept edge; returns #1 after it.
  task automatic start_div(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
  endtask

  // Counts edges after the accept edge until done is seen (or -1 on timeout).
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic div_check(input string tag, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    start_div(a, b);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 14);
    check({tag, "_d"}, 32'(d), 32'(ref_div(a, b)));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(b == 8'h00));
    if (b != 8'h00) check({tag, "_dy"}, 32'(ref_mul(d, b)), 32'(a));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [7:0] ra, rb;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer vectors
    start_div(8'h01, 8'h53);
    wait_done(cyc);
    check("kat1_lat", cyc, 14);
    check("kat1_d", 32'(d), 32'hCA);
    check("kat1_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    start_div(8'hC1, 8'h83);
    wait_done(cyc);
    check("kat2_d", 32'(d), 32'h57);
    @(posedge clk); #1;
    start_div(8'h56, 8'h01);
    wait_done(cyc);
    check("kat3_d", 32'(d), 32'h56);
    @(posedge clk); #1;
    start_div(8'h46, 8'h00);
    wait_done(cyc);
    check("zero_lat", cyc, 14);
    check("zero_d", 32'(d), 32'h00);
    check("zero_dz", 32'(div_by_zero), 32'd1);
    @(posedge clk); #1;

    div_check("p1", 8'h56, 8'h12);
    div_check("p2", 8'h46, 8'h4C);
    div_check("p3", 8'h02, 8'h4C);
    div_check("p4", 8'h13, 8'h5C);
    div_check("x0", 8'h00, 8'h37);
    div_check("y0", 8'hFF, 8'h00);

    // start held high (with changing operands) during RUN is ignored
    start = 1'b1;
    x = 8'h9A;
    y = 8'h3E;
    @(posedge clk);
    cyc = -1;
    for (int n = 1; n <= 30; n++) begin
      #1;
      if (n <= 10) begin
        x = 8'($urandom);
        y = 8'($urandom);
      end else start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        cyc = n;
        break;
      end
    end
    check("hold_lat", cyc, 14);
    check("hold_d", 32'(d), 32'(ref_div(8'h9A, 8'h3E)));

    // Back-to-back: start in the done cycle is accepted
    start = 1'b1;
    x = 8'h21;
    y = 8'hE7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_dheld", 32'(d), 32'(ref_div(8'h9A, 8'h3E)));
    wait_done(cyc);
    check("b2b_lat", cyc, 14);
    check("b2b_d", 32'(d), 32'(ref_div(8'h21, 8'hE7)));
    @(posedge clk); #1;

    // Asynchronous reset at step 6 aborts without a done pulse
    start_div(8'h77, 8'h19);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_nodone", pulses, 0);

    // Random operands, y != 0
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      start_div(ra, rb);
      wait_done(cyc);
      check("rnd_lat", cyc, 14);
      check("rnd_d", 32'(d), 32'(ref_div(ra, rb)));
      check("rnd_dy", 32'(ref_mul(d, rb)), 32'(ra));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
